// File: rtl/vram_fill_scheduler.sv
// -----------------------------------------------------------------------------
// vram_fill_scheduler
//   Shares the single write port of the 32x32x3-bit video memory between the
//   CPU WVM path (absolute priority) and a rectangle-fill engine that writes
//   one cell per free cycle in raster order.
//
// Ports
//   Clock, Reset                 rising-edge clock, synchronous active-high reset
//   iCpuWrite/iCpuAddr/iCpuData  CPU write request (one write per high cycle)
//   iFillStart                   fill command strobe (ignored while busy)
//   iFillX0/X1, iFillY0/Y1       inclusive rectangle bounds, any order
//   iFillColor                   fill color
//   iFillAbort                   cancels an in-progress fill
//   iBlank                       vertical blank (gates fill when BLANK_ONLY=1)
//   oVmWriteEnable/Address/DataIn registered video-memory write port
//   oFillBusy                    high while in FILL
//   oFillDone                    one-cycle pulse on normal completion
//   oDbgState                    current FSM state (IDLE=0, FILL=1, DONE=2)
//
// Handshake: iCpuWrite has no ready; it is always accepted and appears on the
// port the next cycle. The fill engine only uses cycles the CPU leaves free,
// retrying the same cell until it is issued.
// -----------------------------------------------------------------------------
module vram_fill_scheduler #(
  parameter bit BLANK_ONLY = 1'b0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iCpuWrite,
  input  logic [9:0] iCpuAddr,
  input  logic [2:0] iCpuData,
  input  logic       iFillStart,
  input  logic [4:0] iFillX0,
  input  logic [4:0] iFillX1,
  input  logic [4:0] iFillY0,
  input  logic [4:0] iFillY1,
  input  logic [2:0] iFillColor,
  input  logic       iFillAbort,
  input  logic       iBlank,
  output logic       oVmWriteEnable,
  output logic [9:0] oVmWriteAddress,
  output logic [2:0] oVmDataIn,
  output logic       oFillBusy,
  output logic       oFillDone,
  output logic [1:0] oDbgState
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic [4:0] ymin_q, ymin_d, ymax_q, ymax_d;
  logic [4:0] cx_q, cx_d, cy_q, cy_d;
  logic [2:0] color_q, color_d;
  logic       we_q, we_d;
  logic [9:0] waddr_q, waddr_d;
  logic [2:0] wdata_q, wdata_d;

  logic       issue;
  logic       last_cell;
  logic       accept_start;
  logic       slot_free;

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: state_d = accept_start ? ST_FILL : ST_IDLE;
      ST_FILL: begin
        if (iFillAbort) begin
          state_d = ST_IDLE;
        end else if (issue && last_cell) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    oFillBusy    = (state_q == ST_FILL);
    oFillDone    = (state_q == ST_DONE);
    oDbgState    = state_q;
    // A slot is free when the CPU is silent and, in blank-only mode, the
    // display is blanked.
    slot_free    = !iCpuWrite && ((BLANK_ONLY == 1'b0) || iBlank);
    // Abort suppresses the issue in its own cycle so nothing new is queued.
    issue        = (state_q == ST_FILL) && slot_free && !iFillAbort;
    last_cell    = (cx_q == xmax_q) && (cy_q == ymax_q);
    accept_start = iFillStart && (state_q != ST_FILL);
  end

  // Bounds capture and raster cursor
  always_comb begin
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    color_d = color_q;
    if (accept_start) begin
      xmin_d  = (iFillX0 < iFillX1) ? iFillX0 : iFillX1;
      xmax_d  = (iFillX0 < iFillX1) ? iFillX1 : iFillX0;
      ymin_d  = (iFillY0 < iFillY1) ? iFillY0 : iFillY1;
      ymax_d  = (iFillY0 < iFillY1) ? iFillY1 : iFillY0;
      cx_d    = (iFillX0 < iFillX1) ? iFillX0 : iFillX1;
      cy_d    = (iFillY0 < iFillY1) ? iFillY0 : iFillY1;
      color_d = iFillColor;
    end else if (issue && !last_cell) begin
      // Bounds never exceed 31, so the 5-bit increments cannot wrap here.
      if (cx_q < xmax_q) begin
        cx_d = cx_q + 5'd1;
      end else begin
        cx_d = xmin_q;
        cy_d = cy_q + 5'd1;
      end
    end
  end

  // Write-port mux: CPU first, then fill; address/data hold when idle.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (iCpuWrite) begin
      we_d    = 1'b1;
      waddr_d = iCpuAddr;
      wdata_d = iCpuData;
    end else if (issue) begin
      we_d    = 1'b1;
      waddr_d = {cy_q, cx_q};
      wdata_d = color_q;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      xmin_q  <= 5'd0;
      xmax_q  <= 5'd0;
      ymin_q  <= 5'd0;
      ymax_q  <= 5'd0;
      cx_q    <= 5'd0;
      cy_q    <= 5'd0;
      color_q <= 3'd0;
      we_q    <= 1'b0;
      waddr_q <= 10'd0;
      wdata_q <= 3'd0;
    end else begin
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      color_q <= color_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign oVmWriteEnable  = we_q;
  assign oVmWriteAddress = waddr_q;
  assign oVmDataIn       = wdata_q;

endmodule

// File: tb/tb_vram_fill_scheduler.sv
// -----------------------------------------------------------------------------
// tb_vram_fill_scheduler
//   Directed bench for vram_fill_scheduler. u_dut runs with BLANK_ONLY=0 and
//   is scoreboarded on every write; u_blank (BLANK_ONLY=1) shares the inputs
//   and is checked directly in the blank-gating step.
// -----------------------------------------------------------------------------
module tb_vram_fill_scheduler;

  // Clock / reset
  logic       Clock = 1'b0;
  logic       Reset;
  always #5 Clock = ~Clock;

  logic       iCpuWrite;
  logic [9:0] iCpuAddr;
  logic [2:0] iCpuData;
  logic       iFillStart;
  logic [4:0] iFillX0, iFillX1, iFillY0, iFillY1;
  logic [2:0] iFillColor;
  logic       iFillAbort;
  logic       iBlank;

  logic       oVmWriteEnable;
  logic [9:0] oVmWriteAddress;
  logic [2:0] oVmDataIn;
  logic       oFillBusy, oFillDone;
  logic [1:0] oDbgState;

  logic       b_we;
  logic [9:0] b_addr;
  logic [2:0] b_data;
  logic       b_busy, b_done;
  logic [1:0] b_state;

  vram_fill_scheduler #(.BLANK_ONLY(1'b0)) u_dut (
    .Clock(Clock), .Reset(Reset),
    .iCpuWrite(iCpuWrite), .iCpuAddr(iCpuAddr), .iCpuData(iCpuData),
    .iFillStart(iFillStart), .iFillX0(iFillX0), .iFillX1(iFillX1),
    .iFillY0(iFillY0), .iFillY1(iFillY1), .iFillColor(iFillColor),
    .iFillAbort(iFillAbort), .iBlank(iBlank),
    .oVmWriteEnable(oVmWriteEnable), .oVmWriteAddress(oVmWriteAddress),
    .oVmDataIn(oVmDataIn), .oFillBusy(oFillBusy), .oFillDone(oFillDone),
    .oDbgState(oDbgState)
  );

  vram_fill_scheduler #(.BLANK_ONLY(1'b1)) u_blank (
    .Clock(Clock), .Reset(Reset),
    .iCpuWrite(iCpuWrite), .iCpuAddr(iCpuAddr), .iCpuData(iCpuData),
    .iFillStart(iFillStart), .iFillX0(iFillX0), .iFillX1(iFillX1),
    .iFillY0(iFillY0), .iFillY1(iFillY1), .iFillColor(iFillColor),
    .iFillAbort(iFillAbort), .iBlank(iBlank),
    .oVmWriteEnable(b_we), .oVmWriteAddress(b_addr),
    .oVmDataIn(b_data), .oFillBusy(b_busy), .oFillDone(b_done),
    .oDbgState(b_state)
  );

  // Scoreboard: {addr, data} expected on u_dut's port, in port order.
  logic [12:0] fill_exp_q[$];
  logic [12:0] cpu_exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        cpu_at_edge = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic push_rect(input int x0, input int x1, input int y0, input int y1,
                           input logic [2:0] col);
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        fill_exp_q.push_back({y[4:0], x[4:0], col});
      end
    end
  endtask

  task automatic start_fill(input logic [4:0] x0, input logic [4:0] x1,
                            input logic [4:0] y0, input logic [4:0] y1,
                            input logic [2:0] col);
    iFillStart = 1'b1;
    iFillX0    = x0;
    iFillX1    = x1;
    iFillY0    = y0;
    iFillY1    = y1;
    iFillColor = col;
  endtask

  // Remember whether a CPU strobe was accepted at each edge.
  always @(posedge Clock) cpu_at_edge <= iCpuWrite && !Reset;

  // Port monitor: every write is matched against the proper queue.
  always @(negedge Clock) begin
    logic [12:0] e;
    if (cpu_at_edge) begin
      chk("cpu_we", {31'd0, oVmWriteEnable}, 32'd1);
      if (cpu_exp_q.size() > 0) begin
        e = cpu_exp_q.pop_front();
        chk("cpu_wr", {19'd0, oVmWriteAddress, oVmDataIn}, {19'd0, e});
      end else begin
        chk("unexpected_cpu_wr", {31'd0, oVmWriteEnable}, 32'd0);
      end
    end else if (oVmWriteEnable === 1'b1) begin
      if (fill_exp_q.size() > 0) begin
        e = fill_exp_q.pop_front();
        chk("fill_wr", {19'd0, oVmWriteAddress, oVmDataIn}, {19'd0, e});
      end else begin
        chk("unexpected_fill_wr", {31'd0, oVmWriteEnable}, 32'd0);
      end
    end
  end

  // Global time limit
  initial begin
    #500000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int busy_cycles;
    int strobes;
    int blank_wr;

    Reset = 1'b1;
    iCpuWrite = 1'b0; iCpuAddr = '0; iCpuData = '0;
    iFillStart = 1'b0; iFillX0 = '0; iFillX1 = '0; iFillY0 = '0; iFillY1 = '0;
    iFillColor = '0; iFillAbort = 1'b0; iBlank = 1'b1;
    tick(); tick(); tick();
    Reset = 1'b0;
    chk("rst_we",    {31'd0, oVmWriteEnable}, 32'd0);
    chk("rst_addr",  {22'd0, oVmWriteAddress}, 32'd0);
    chk("rst_data",  {29'd0, oVmDataIn}, 32'd0);
    chk("rst_busy",  {31'd0, oFillBusy}, 32'd0);
    chk("rst_done",  {31'd0, oFillDone}, 32'd0);
    chk("rst_state", {30'd0, oDbgState}, 32'd0);
    tick();

    // Small fill with reversed X bounds: cells 65,66,67 color 5.
    start_fill(5'd3, 5'd1, 5'd2, 5'd2, 3'd5);
    push_rect(1, 3, 2, 2, 3'd5);
    tick();                                   // t+1
    iFillStart = 1'b0;
    chk("f1_busy_t1", {31'd0, oFillBusy}, 32'd1);
    chk("f1_we_t1",   {31'd0, oVmWriteEnable}, 32'd0);
    tick();                                   // t+2
    chk("f1_we_t2",   {31'd0, oVmWriteEnable}, 32'd1);
    chk("f1_addr_t2", {22'd0, oVmWriteAddress}, 32'd65);
    tick();                                   // t+3
    chk("f1_busy_t3", {31'd0, oFillBusy}, 32'd1);
    chk("f1_done_t3", {31'd0, oFillDone}, 32'd0);
    tick();                                   // t+4
    chk("f1_done_t4", {31'd0, oFillDone}, 32'd1);
    chk("f1_busy_t4", {31'd0, oFillBusy}, 32'd0);
    chk("f1_addr_t4", {22'd0, oVmWriteAddress}, 32'd67);
    tick();                                   // t+5
    chk("f1_done_t5", {31'd0, oFillDone}, 32'd0);
    chk("f1_we_t5",   {31'd0, oVmWriteEnable}, 32'd0);

    // Full screen, CPU strobe on every 4th FILL cycle.
    start_fill(5'd0, 5'd31, 5'd0, 5'd31, 3'd2);
    push_rect(0, 31, 0, 31, 3'd2);
    tick();
    iFillStart = 1'b0;
    busy_cycles = 0;
    strobes = 0;
    k = 0;
    while (oFillBusy === 1'b1 && k < 4000) begin
      if (k % 4 == 3) begin
        iCpuWrite = 1'b1;
        iCpuAddr  = 10'h155;
        iCpuData  = 3'd7;
        cpu_exp_q.push_back({10'h155, 3'd7});
        strobes++;
      end else begin
        iCpuWrite = 1'b0;
      end
      busy_cycles++;
      k++;
      tick();
    end
    iCpuWrite = 1'b0;
    chk("full_done",        {31'd0, oFillDone}, 32'd1);
    chk("full_busy_cycles", busy_cycles, 1024 + strobes);
    tick(); tick();
    chk("full_fill_q_empty", fill_exp_q.size(), 32'd0);
    chk("full_cpu_q_empty",  cpu_exp_q.size(), 32'd0);

    // Blank-only gating on u_blank; u_dut also fills the cell immediately.
    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    iBlank = 1'b0;
    start_fill(5'd10, 5'd10, 5'd10, 5'd10, 3'd3);
    fill_exp_q.push_back({10'd330, 3'd3});
    tick();
    iFillStart = 1'b0;
    blank_wr = 0;
    for (int i = 0; i < 50; i++) begin
      if (b_we === 1'b1) blank_wr++;
      tick();
    end
    chk("blank_no_wr",  blank_wr, 32'd0);
    chk("blank_busy",   {31'd0, b_busy}, 32'd1);
    iBlank = 1'b1;                            // first blank cycle
    tick();
    chk("blank_we",     {31'd0, b_we}, 32'd1);
    chk("blank_addr",   {22'd0, b_addr}, 32'd330);
    chk("blank_data",   {29'd0, b_data}, 32'd3);
    chk("blank_done",   {31'd0, b_done}, 32'd1);
    tick();
    chk("blank_we_off", {31'd0, b_we}, 32'd0);

    // Abort a 4x4 fill after 5 issues.
    start_fill(5'd0, 5'd3, 5'd3, 5'd0, 3'd6);
    fill_exp_q.push_back({10'd0, 3'd6});
    fill_exp_q.push_back({10'd1, 3'd6});
    fill_exp_q.push_back({10'd2, 3'd6});
    fill_exp_q.push_back({10'd3, 3'd6});
    fill_exp_q.push_back({10'd32, 3'd6});
    tick();                                   // FILL cycle 1
    iFillStart = 1'b0;
    for (int i = 0; i < 5; i++) tick();       // FILL cycle 6
    iFillAbort = 1'b1;
    chk("abort_busy_a", {31'd0, oFillBusy}, 32'd1);
    tick();
    iFillAbort = 1'b0;
    chk("abort_busy_a1", {31'd0, oFillBusy}, 32'd0);
    chk("abort_done_a1", {31'd0, oFillDone}, 32'd0);
    chk("abort_we_a1",   {31'd0, oVmWriteEnable}, 32'd0);
    tick();
    chk("abort_done_a2", {31'd0, oFillDone}, 32'd0);
    chk("abort_q_empty", fill_exp_q.size(), 32'd0);
    start_fill(5'd5, 5'd5, 5'd5, 5'd5, 3'd1);
    fill_exp_q.push_back({10'd165, 3'd1});
    tick();
    iFillStart = 1'b0;
    chk("restart_busy", {31'd0, oFillBusy}, 32'd1);
    tick();
    chk("restart_addr", {22'd0, oVmWriteAddress}, 32'd165);
    chk("restart_done", {31'd0, oFillDone}, 32'd1);
    tick();

    // Reset mid-fill after two issues.
    start_fill(5'd7, 5'd0, 5'd0, 5'd0, 3'd6);
    fill_exp_q.push_back({10'd0, 3'd6});
    fill_exp_q.push_back({10'd1, 3'd6});
    tick();                                   // F1
    iFillStart = 1'b0;
    tick();                                   // F2
    tick();                                   // F3
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("mrst_we",   {31'd0, oVmWriteEnable}, 32'd0);
    chk("mrst_addr", {22'd0, oVmWriteAddress}, 32'd0);
    chk("mrst_data", {29'd0, oVmDataIn}, 32'd0);
    chk("mrst_busy", {31'd0, oFillBusy}, 32'd0);
    chk("mrst_done", {31'd0, oFillDone}, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("mrst_q_empty", fill_exp_q.size(), 32'd0);
    chk("mrst_idle",    {31'd0, oFillBusy}, 32'd0);

    // Start during FILL is ignored; start in DONE chains with no gap.
    start_fill(5'd4, 5'd2, 5'd1, 5'd1, 3'd4);
    push_rect(2, 4, 1, 1, 3'd4);
    tick();                                   // t+1
    start_fill(5'd10, 5'd20, 5'd5, 5'd6, 3'd7);
    tick();                                   // t+2
    iFillStart = 1'b0;
    tick();                                   // t+3
    tick();                                   // t+4 DONE
    chk("chain_done", {31'd0, oFillDone}, 32'd1);
    start_fill(5'd6, 5'd6, 5'd1, 5'd0, 3'd1);
    fill_exp_q.push_back({10'd6, 3'd1});
    fill_exp_q.push_back({10'd38, 3'd1});
    tick();
    iFillStart = 1'b0;
    chk("chain_busy",  {31'd0, oFillBusy}, 32'd1);
    tick();
    chk("chain_we",    {31'd0, oVmWriteEnable}, 32'd1);
    chk("chain_addr1", {22'd0, oVmWriteAddress}, 32'd6);
    tick();
    chk("chain_addr2", {22'd0, oVmWriteAddress}, 32'd38);
    chk("chain_done2", {31'd0, oFillDone}, 32'd1);
    tick(); tick();
    chk("end_fill_q_empty", fill_exp_q.size(), 32'd0);
    chk("end_cpu_q_empty",  cpu_exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
